// File: rtl/snitch_icache_tag_ctrl.sv
// snitch_icache_tag_ctrl
//
// Access controller for the single-port instruction-cache tag SRAM. The port
// has one request per cycle, one-cycle read latency and per-way byte enables.
// It is shared by three users, with fixed priority from highest to lowest:
//   1. the internal flush sequencer, which walks every line and clears all ways
//   2. the refill stage, which issues tag writes
//   3. the lookup stage, which issues tag reads
//
// Optional feature macro: SNITCH_ICACHE_TAG_INIT_ON_RESET_EN
//   When defined, the controller leaves reset already inside a flush walk, so
//   the whole tag array is cleared without an explicit request. When it is
//   undefined, the controller resets to IDLE and leaves the tags untouched.
//
// Ports:
//   clk_i, rst_i        clock and asynchronous active-high reset
//   flush_valid_i       full-invalidate request, held until flush_ready_o
//   flush_ready_o       one-cycle pulse when the walk has completed
//   busy_o              flush walk in progress
//   lookup_*            read request, grant, registered valid and masked data
//   write_*             refill write request (address, entry, way enables), grant
//   sram_*              tag memory macro interface
module snitch_icache_tag_ctrl #(
    parameter  int LINE_COUNT = 128,
    parameter  int WAY_COUNT  = 4,
    parameter  int TAG_WIDTH  = 20,
    localparam int ADDR_W     = $clog2(LINE_COUNT),
    localparam int ENTRY_W    = WAY_COUNT * (TAG_WIDTH + 2)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_valid_i,
    output logic               flush_ready_o,
    output logic               busy_o,
    input  logic               lookup_req_i,
    input  logic [ADDR_W-1:0]  lookup_addr_i,
    output logic               lookup_gnt_o,
    output logic               lookup_rvalid_o,
    output logic [ENTRY_W-1:0] lookup_rdata_o,
    input  logic               write_req_i,
    input  logic [ADDR_W-1:0]  write_addr_i,
    input  logic [ENTRY_W-1:0] write_wdata_i,
    input  logic [WAY_COUNT-1:0] write_be_i,
    output logic               write_gnt_o,
    output logic               sram_req_o,
    output logic               sram_we_o,
    output logic [ADDR_W-1:0]  sram_addr_o,
    output logic [ENTRY_W-1:0] sram_wdata_o,
    output logic [WAY_COUNT-1:0] sram_be_o,
    input  logic [ENTRY_W-1:0] sram_rdata_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(LINE_COUNT - 1);

`ifdef SNITCH_ICACHE_TAG_INIT_ON_RESET_EN
    localparam state_e RESET_STATE = FLUSH;
`else
    localparam state_e RESET_STATE = IDLE;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rvalid_q, rvalid_d;

    // Arbitration and SRAM request mux. Grants are combinational so the
    // winner's request goes to the SRAM in the same cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_gnt_o  = 1'b0;
        lookup_gnt_o = 1'b0;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;

        unique case (state_q)
            IDLE: begin
                if (write_req_i) begin
                    write_gnt_o  = 1'b1;
                    sram_req_o   = 1'b1;
                    sram_we_o    = 1'b1;
                    sram_addr_o  = write_addr_i;
                    sram_wdata_o = write_wdata_i;
                    sram_be_o    = write_be_i;
                end else if (lookup_req_i) begin
                    lookup_gnt_o = 1'b1;
                    sram_req_o   = 1'b1;
                    sram_addr_o  = lookup_addr_i;
                    sram_be_o    = '1;
                end
                // A pending flush does not block this cycle's write/lookup;
                // the walk starts on the next cycle.
                if (flush_valid_i) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                sram_req_o  = 1'b1;
                sram_we_o   = 1'b1;
                sram_addr_o = cnt_q;
                sram_be_o   = '1;
                // Terminal compare happens before the increment would wrap.
                if (cnt_q == LAST_LINE) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        rvalid_d = lookup_gnt_o;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= RESET_STATE;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign busy_o          = (state_q == FLUSH);
    assign flush_ready_o   = (state_q == DONE);
    assign lookup_rvalid_o = rvalid_q;
    // Hide whatever the SRAM drives on cycles without a read response.
    assign lookup_rdata_o  = rvalid_q ? sram_rdata_i : '0;

endmodule

// File: tb/tb_snitch_icache_tag_ctrl.sv
module tb_snitch_icache_tag_ctrl;

    localparam int AW = 7;
    localparam int EW = 88;
    localparam int LW = 22;
    localparam int LC = 128;

`ifdef SNITCH_ICACHE_TAG_INIT_ON_RESET_EN
    localparam logic INIT_EN = 1'b1;
`else
    localparam logic INIT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_i;
    logic          flush_valid_i;
    logic          flush_ready_o;
    logic          busy_o;
    logic          lookup_req_i;
    logic [AW-1:0] lookup_addr_i;
    logic          lookup_gnt_o;
    logic          lookup_rvalid_o;
    logic [EW-1:0] lookup_rdata_o;
    logic          write_req_i;
    logic [AW-1:0] write_addr_i;
    logic [EW-1:0] write_wdata_i;
    logic [3:0]    write_be_i;
    logic          write_gnt_o;
    logic          sram_req_o;
    logic          sram_we_o;
    logic [AW-1:0] sram_addr_o;
    logic [EW-1:0] sram_wdata_o;
    logic [3:0]    sram_be_o;
    logic [EW-1:0] sram_rdata_i;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    snitch_icache_tag_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .flush_valid_i   (flush_valid_i),
        .flush_ready_o   (flush_ready_o),
        .busy_o          (busy_o),
        .lookup_req_i    (lookup_req_i),
        .lookup_addr_i   (lookup_addr_i),
        .lookup_gnt_o    (lookup_gnt_o),
        .lookup_rvalid_o (lookup_rvalid_o),
        .lookup_rdata_o  (lookup_rdata_o),
        .write_req_i     (write_req_i),
        .write_addr_i    (write_addr_i),
        .write_wdata_i   (write_wdata_i),
        .write_be_i      (write_be_i),
        .write_gnt_o     (write_gnt_o),
        .sram_req_o      (sram_req_o),
        .sram_we_o       (sram_we_o),
        .sram_addr_o     (sram_addr_o),
        .sram_wdata_o    (sram_wdata_o),
        .sram_be_o       (sram_be_o),
        .sram_rdata_i    (sram_rdata_i)
    );

    // Behavioural tag SRAM: one-cycle read latency, per-way write enables,
    // random garbage on the read bus when no read was issued.
    logic [EW-1:0] mem [LC];
    logic          mem_init;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int l = 0; l < LC; l++) mem[l] <= EW'({$urandom, $urandom, $urandom});
            sram_rdata_i <= '0;
        end else if (sram_req_o && sram_we_o) begin
            for (int w = 0; w < 4; w++)
                if (sram_be_o[w]) mem[sram_addr_o][w*LW +: LW] <= sram_wdata_o[w*LW +: LW];
            sram_rdata_i <= EW'({$urandom, $urandom, $urandom});
        end else if (sram_req_o) begin
            sram_rdata_i <= mem[sram_addr_o];
        end else begin
            sram_rdata_i <= EW'({$urandom, $urandom, $urandom});
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Read scoreboard: expected entry pushed at grant, popped at rvalid.
    logic [EW-1:0] rq [$];
    logic          exp_rv = 1'b0;

    always @(negedge clk) begin
        if (rst_i) begin
            rq.delete();
            exp_rv = 1'b0;
        end else begin
            chk("rvalid", lookup_rvalid_o, exp_rv);
            if (exp_rv) begin
                if (rq.size() == 0) chk("rdata_queue_empty", 1'b1, 1'b0);
                else chk("rdata", lookup_rdata_o, rq.pop_front());
            end else begin
                chk("rdata_masked", lookup_rdata_o, 0);
            end
            exp_rv = lookup_gnt_o;
            if (lookup_gnt_o) rq.push_back(mem[lookup_addr_i]);
        end
    end

    typedef struct {
        logic          wr;
        logic          lk;
        logic [AW-1:0] waddr;
        logic [AW-1:0] laddr;
        logic [EW-1:0] wdata;
        logic [3:0]    be;
        logic          e_wgnt;
        logic          e_lgnt;
        logic          e_req;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [3:0]    e_be;
    } vec_t;

    function automatic vec_t mk(logic wr, logic lk, logic [AW-1:0] wa, logic [AW-1:0] la,
                                logic [EW-1:0] wd, logic [3:0] be,
                                logic eg, logic el, logic er, logic ew,
                                logic [AW-1:0] ea, logic [3:0] eb);
        vec_t v;
        v.wr = wr; v.lk = lk; v.waddr = wa; v.laddr = la; v.wdata = wd; v.be = be;
        v.e_wgnt = eg; v.e_lgnt = el; v.e_req = er; v.e_we = ew; v.e_addr = ea; v.e_be = eb;
        return v;
    endfunction

    task automatic idle_inputs();
        flush_valid_i = 1'b0;
        lookup_req_i  = 1'b0;
        lookup_addr_i = '0;
        write_req_i   = 1'b0;
        write_addr_i  = '0;
        write_wdata_i = '0;
        write_be_i    = '0;
    endtask

    initial begin
        vec_t          vt [11];
        logic [EW-1:0] d1, d2, d3;
        int            bad;
        logic          seen;

        d1 = 88'h0123456789ABCDEF012345;
        d2 = 88'hFEDCBA9876543210FEDCBA;
        d3 = 88'h5A5A5A5AA5A5A5A55A5A5A;
        //         wr lk wa  la  wdata be    wg lg rq we addr be
        vt[0]  = mk(0, 0, 0,  0,  '0,   4'h0, 0, 0, 0, 0, 0,  4'h0);
        vt[1]  = mk(0, 1, 0,  5,  '0,   4'h0, 0, 1, 1, 0, 5,  4'hF);
        vt[2]  = mk(0, 0, 0,  0,  '0,   4'h0, 0, 0, 0, 0, 0,  4'h0);
        vt[3]  = mk(1, 1, 3,  7,  d1,   4'h5, 1, 0, 1, 1, 3,  4'h5);
        vt[4]  = mk(0, 1, 0,  7,  '0,   4'h0, 0, 1, 1, 0, 7,  4'hF);
        vt[5]  = mk(1, 0, 7,  0,  d2,   4'h8, 1, 0, 1, 1, 7,  4'h8);
        vt[6]  = mk(0, 1, 0,  7,  '0,   4'h0, 0, 1, 1, 0, 7,  4'hF);
        vt[7]  = mk(0, 1, 0,  3,  '0,   4'h0, 0, 1, 1, 0, 3,  4'hF);
        vt[8]  = mk(1, 1, 9,  9,  d3,   4'hF, 1, 0, 1, 1, 9,  4'hF);
        vt[9]  = mk(0, 1, 0,  9,  '0,   4'h0, 0, 1, 1, 0, 9,  4'hF);
        vt[10] = mk(0, 0, 0,  0,  '0,   4'h0, 0, 0, 0, 0, 0,  4'h0);

        idle_inputs();
        rst_i    = 1'b1;
        mem_init = 1'b1;
        #3;
        chk("reset_busy", busy_o, INIT_EN);
        chk("reset_ready", flush_ready_o, 0);
        chk("reset_gnts", {write_gnt_o, lookup_gnt_o, lookup_rvalid_o}, 0);
        chk("reset_sram", {sram_req_o, sram_we_o}, {INIT_EN, INIT_EN});
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_init = 1'b0;
        rst_i    = 1'b0;

        if (INIT_EN) begin
            int zw = 0;
            seen = 1'b0;
            for (int c = 0; c < 200 && !seen; c++) begin
                @(negedge clk);
                if (flush_ready_o) seen = 1'b1;
                else if (sram_req_o && sram_we_o && busy_o && sram_wdata_o == '0 &&
                         sram_be_o == 4'hF && sram_addr_o == AW'(zw)) zw++;
            end
            chk("init_walk_ready", seen, 1);
            chk("init_walk_writes", zw, LC);
        end else begin
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                chk("no_init_sram_idle", {sram_req_o, busy_o}, 0);
            end
        end

        // Table-driven arbitration and read-path vectors in IDLE.
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            write_req_i   = vt[i].wr;
            write_addr_i  = vt[i].waddr;
            write_wdata_i = vt[i].wdata;
            write_be_i    = vt[i].be;
            lookup_req_i  = vt[i].lk;
            lookup_addr_i = vt[i].laddr;
            @(negedge clk);
            chk($sformatf("v%0d_gnts", i), {write_gnt_o, lookup_gnt_o}, {vt[i].e_wgnt, vt[i].e_lgnt});
            chk($sformatf("v%0d_req", i), {sram_req_o, busy_o}, {vt[i].e_req, 1'b0});
            if (vt[i].e_req)
                chk($sformatf("v%0d_cmd", i), {sram_we_o, sram_addr_o, sram_be_o},
                    {vt[i].e_we, vt[i].e_addr, vt[i].e_be});
            if (vt[i].e_we)
                chk($sformatf("v%0d_wdata", i), sram_wdata_o, vt[i].wdata);
        end

        // Flush request together with a write: the write is served first.
        @(posedge clk); #1;
        idle_inputs();
        flush_valid_i = 1'b1;
        write_req_i   = 1'b1;
        write_addr_i  = 2;
        write_wdata_i = d1;
        write_be_i    = 4'hF;
        @(negedge clk);
        chk("flushreq_write_gnt", {write_gnt_o, sram_addr_o, busy_o}, {1'b1, 7'd2, 1'b0});
        @(posedge clk); #1;
        write_addr_i  = 4;
        write_wdata_i = d2;
        lookup_req_i  = 1'b1;
        lookup_addr_i = 6;
        for (int i = 0; i < LC; i++) begin
            if (i != 0) @(posedge clk);
            @(negedge clk);
            chk($sformatf("walk_%0d", i),
                {busy_o, sram_req_o, sram_we_o, sram_addr_o, sram_be_o, sram_wdata_o == '0,
                 write_gnt_o, lookup_gnt_o, flush_ready_o},
                {1'b1, 1'b1, 1'b1, AW'(i), 4'hF, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        @(negedge clk);
        chk("done_pulse", {flush_ready_o, busy_o, sram_req_o, write_gnt_o, lookup_gnt_o}, 5'b10000);
        flush_valid_i = 1'b0;
        @(negedge clk);
        chk("after_done_write", {flush_ready_o, busy_o, write_gnt_o, lookup_gnt_o, sram_addr_o},
            {4'b0010, 7'd4});
        @(posedge clk); #1;
        write_req_i = 1'b0;
        @(negedge clk);
        chk("after_done_lookup", {write_gnt_o, lookup_gnt_o, sram_addr_o}, {2'b01, 7'd6});
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        bad = 0;
        for (int l = 0; l < LC; l++) if (l != 4 && mem[l] != '0) bad++;
        chk("mem_cleared_lines", bad, 0);
        chk("mem_line4_written", mem[4], d2);

        // Reset in the middle of a walk, then restart from line 0.
        @(posedge clk); #1;
        flush_valid_i = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (busy_o && sram_addr_o == 7'd40) seen = 1'b1;
        end
        chk("reach_line_40", seen, 1);
        #1;
        rst_i = 1'b1;
        flush_valid_i = INIT_EN ? 1'b0 : 1'b1;
        #1;
        chk("midreset_outputs",
            {flush_ready_o, busy_o, write_gnt_o, lookup_gnt_o, lookup_rvalid_o, sram_req_o, sram_we_o},
            {1'b0, INIT_EN, 1'b0, 1'b0, 1'b0, INIT_EN, INIT_EN});
        seen = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (flush_ready_o) seen = 1'b1;
        end
        chk("midreset_no_ready", seen, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        if (!INIT_EN) begin
            @(negedge clk);
            chk("restart_req_cycle", busy_o, 0);
        end
        @(posedge clk);
        @(negedge clk);
        chk("restart_addr0", {busy_o, sram_we_o, sram_addr_o}, {2'b11, 7'd0});
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (flush_ready_o) seen = 1'b1;
        end
        chk("restart_ready", seen, 1);
        flush_valid_i = 1'b0;

        for (int c = 0; c < 3; c++) @(negedge clk);
        chk("idle_after_restart", {busy_o, sram_req_o, flush_ready_o}, 0);
        chk("scoreboard_drained", rq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
